// File: rtl/task_dispatch_scheduler.sv
// task_dispatch_scheduler: FIFO task queue with round-robin core dispatch and occupancy-driven DVFS.
// Optional DISPATCH_STATS_EN builds a saturating dispatched-task counter.
module task_dispatch_scheduler #(
  parameter int NUM_CORES = 4,
  parameter int DATA_W    = 32,
  parameter int DEPTH     = 8,
  parameter int HI_THRESH = 6,
  parameter int LO_THRESH = 2,
  parameter int HOLD      = 8,
  parameter int SETTLE    = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       task_valid,
  input  logic [DATA_W-1:0]          task_data,
  output logic                       task_ready,
  input  logic [NUM_CORES-1:0]       core_busy,
  output logic [NUM_CORES-1:0]       disp_valid,
  output logic [DATA_W-1:0]          disp_data,
  output logic [$clog2(DEPTH):0]     occupancy,
  output logic [1:0]                 voltage_level,
  output logic [1:0]                 frequency_level,
  output logic [15:0]                dispatch_count
);
  localparam int AW = $clog2(DEPTH);
  localparam int OW = AW + 1;
  localparam int CW = NUM_CORES > 1 ? $clog2(NUM_CORES) : 1;
  localparam int HW = $clog2(HOLD + 1);
  localparam int SW = $clog2(SETTLE + 1);

  typedef enum logic [1:0] {IDLE, RAISE_F, LOWER_V} state_t;

  logic [DATA_W-1:0]    mem [DEPTH];
  logic [AW-1:0]        wr_ptr, rd_ptr;
  logic [OW-1:0]        count;
  logic [CW-1:0]        rr_ptr, sel, idx;
  logic [NUM_CORES-1:0] eligible;
  logic                 push, pop, found, high, low;
  state_t               state, state_nxt;
  logic [HW-1:0]        hi_cnt, lo_cnt, hi_nxt, lo_nxt;
  logic [SW-1:0]        st_cnt, st_nxt;
  logic [1:0]           volt_nxt, freq_nxt;

  assign occupancy  = count;
  assign task_ready = count < OW'(DEPTH);
  assign push       = task_valid && task_ready;
  // A core strobed last cycle has not yet had a chance to raise busy.
  assign eligible   = ~core_busy & ~disp_valid;
  assign pop        = (count != '0) && found;

  always_comb begin
    sel   = '0;
    found = 1'b0;
    idx   = rr_ptr;
    for (int k = 0; k < NUM_CORES; k++) begin
      if (!found && eligible[idx]) begin
        found = 1'b1;
        sel   = idx;
      end
      idx = (idx == CW'(NUM_CORES - 1)) ? '0 : idx + 1'b1;
    end
  end

  always_ff @(posedge clk)
    if (push) mem[wr_ptr] <= task_data;

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      disp_valid <= '0;
      disp_data  <= '0;
      rr_ptr     <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      count      <= count + OW'(push) - OW'(pop);
      disp_valid <= pop ? NUM_CORES'(1) << sel : '0;
      if (pop) disp_data <= mem[rd_ptr];
      if (pop) rr_ptr <= (sel == CW'(NUM_CORES - 1)) ? '0 : sel + 1'b1;
    end

`ifdef DISPATCH_STATS_EN
  logic [15:0] dcnt;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) dcnt <= '0;
    else if (pop && dcnt != 16'hFFFF) dcnt <= dcnt + 16'd1;
  assign dispatch_count = dcnt;
`else
  assign dispatch_count = '0;
`endif

  assign high = count >= OW'(HI_THRESH);
  assign low  = count <= OW'(LO_THRESH);

  // Voltage leads on the way up and trails on the way down, so frequency never exceeds voltage.
  always_comb begin
    state_nxt = state;
    volt_nxt  = voltage_level;
    freq_nxt  = frequency_level;
    st_nxt    = st_cnt;
    hi_nxt    = '0;
    lo_nxt    = '0;
    unique case (state)
      IDLE: begin
        hi_nxt = !high ? '0 : (hi_cnt == HW'(HOLD)) ? hi_cnt : hi_cnt + 1'b1;
        lo_nxt = !low  ? '0 : (lo_cnt == HW'(HOLD)) ? lo_cnt : lo_cnt + 1'b1;
        if (hi_nxt == HW'(HOLD) && voltage_level != 2'd3) begin
          volt_nxt  = voltage_level + 2'd1;
          state_nxt = RAISE_F;
          st_nxt    = '0;
          hi_nxt    = '0;
          lo_nxt    = '0;
        end else if (lo_nxt == HW'(HOLD) && frequency_level != 2'd0) begin
          freq_nxt  = frequency_level - 2'd1;
          state_nxt = LOWER_V;
          st_nxt    = '0;
          hi_nxt    = '0;
          lo_nxt    = '0;
        end
      end
      RAISE_F: begin
        if (st_cnt == SW'(SETTLE - 1)) begin
          freq_nxt  = frequency_level + 2'd1;
          state_nxt = IDLE;
        end else st_nxt = st_cnt + 1'b1;
      end
      LOWER_V: begin
        if (st_cnt == SW'(SETTLE - 1)) begin
          volt_nxt  = voltage_level - 2'd1;
          state_nxt = IDLE;
        end else st_nxt = st_cnt + 1'b1;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state           <= IDLE;
      hi_cnt          <= '0;
      lo_cnt          <= '0;
      st_cnt          <= '0;
      voltage_level   <= '0;
      frequency_level <= '0;
    end else begin
      state           <= state_nxt;
      hi_cnt          <= hi_nxt;
      lo_cnt          <= lo_nxt;
      st_cnt          <= st_nxt;
      voltage_level   <= volt_nxt;
      frequency_level <= freq_nxt;
    end
endmodule

// File: tb/tb_task_dispatch_scheduler.sv
// tb_task_dispatch_scheduler: directed and randomized checks against a queue-based reference model.
module tb_task_dispatch_scheduler;
  localparam int N = 4, DW = 32, D = 8, HI = 6, LO = 2, HOLD = 8, SETTLE = 4;

  logic          clk = 1'b0;
  logic          rst_n = 1'b1;
  logic          task_valid = 1'b0;
  logic [DW-1:0] task_data = '0;
  logic          task_ready;
  logic [N-1:0]  core_busy = '1;
  logic [N-1:0]  disp_valid;
  logic [DW-1:0] disp_data;
  logic [3:0]    occupancy;
  logic [1:0]    voltage_level, frequency_level;
  logic [15:0]   dispatch_count;

  task_dispatch_scheduler #(
    .NUM_CORES(N), .DATA_W(DW), .DEPTH(D), .HI_THRESH(HI),
    .LO_THRESH(LO), .HOLD(HOLD), .SETTLE(SETTLE)
  ) dut (
    .clk(clk), .rst_n(rst_n), .task_valid(task_valid), .task_data(task_data),
    .task_ready(task_ready), .core_busy(core_busy), .disp_valid(disp_valid),
    .disp_data(disp_data), .occupancy(occupancy), .voltage_level(voltage_level),
    .frequency_level(frequency_level), .dispatch_count(dispatch_count)
  );

  always #5 clk = ~clk;

  int tests = 0, fails = 0;

  logic [DW-1:0] q[$];
  logic [N-1:0]  m_strobe;
  logic [DW-1:0] m_data;
  int rr, volt, freq, mode, hi, lo, st, dcnt;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    q.delete();
    m_strobe = '0;
    m_data = '0;
    rr = 0; volt = 0; freq = 0; mode = 0; hi = 0; lo = 0; st = 0; dcnt = 0;
  endtask

  task automatic model_step(input logic v, input logic [DW-1:0] d, input logic [N-1:0] b);
    int occ, c;
    logic [N-1:0] ns;
    occ = q.size();
    ns = '0;
    if (occ > 0)
      for (int k = 0; k < N; k++) begin
        c = (rr + k) % N;
        if (ns == 0 && !b[c] && !m_strobe[c]) begin
          ns = N'(1) << c;
          m_data = q.pop_front();
          rr = (c + 1) % N;
          if (dcnt < 65535) dcnt++;
        end
      end
    m_strobe = ns;
    if (v && occ < D) q.push_back(d);
    if (mode == 0) begin
      hi = (occ >= HI) ? hi + 1 : 0;
      lo = (occ <= LO) ? lo + 1 : 0;
      if (hi >= HOLD && volt < 3) begin
        volt++; mode = 1; st = 0; hi = 0; lo = 0;
      end else if (lo >= HOLD && freq > 0) begin
        freq--; mode = 2; st = 0; hi = 0; lo = 0;
      end
    end else begin
      hi = 0; lo = 0; st++;
      if (st == SETTLE) begin
        if (mode == 1) freq++; else volt--;
        mode = 0;
      end
    end
  endtask

  task automatic compare_all();
    check("ready", task_ready, q.size() < D);
    check("occupancy", occupancy, q.size());
    check("disp_valid", disp_valid, m_strobe);
    if (m_strobe != 0) check("disp_data", disp_data, m_data);
    check("voltage", voltage_level, volt);
    check("frequency", frequency_level, freq);
`ifdef DISPATCH_STATS_EN
    check("dispatch_count", dispatch_count, dcnt);
`else
    check("dispatch_count", dispatch_count, 0);
`endif
  endtask

  task automatic step(input logic v, input logic [DW-1:0] d, input logic [N-1:0] b);
    task_valid = v;
    task_data  = d;
    core_busy  = b;
    model_step(v, d, b);
    @(posedge clk);
    @(negedge clk);
    compare_all();
  endtask

  task automatic apply_reset();
    task_valid = 1'b0;
    core_busy  = '1;
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    check("rst_occupancy", occupancy, 0);
    check("rst_disp_valid", disp_valid, 0);
    check("rst_disp_data", disp_data, 0);
    check("rst_voltage", voltage_level, 0);
    check("rst_frequency", frequency_level, 0);
    check("rst_dispatch_count", dispatch_count, 0);
    @(negedge clk);
    rst_n = 1'b1;
    check("rst_ready", task_ready, 1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int n;
    logic seen;
    int pv, pb;
    logic [N-1:0] b;
    apply_reset();

    for (int i = 0; i < 8; i++) step(1'b1, 32'hA0 + i, '1);
    check("full_occupancy", occupancy, 8);
    check("full_ready", task_ready, 0);
    step(1'b1, 32'hDEAD, '1);
    check("full_ninth_rejected", occupancy, 8);

    apply_reset();
    for (int i = 0; i < 4; i++) step(1'b1, 32'hB0 + i, '1);
    for (int i = 0; i < 4; i++) begin
      step(1'b0, '0, '0);
      check("rr_strobe", disp_valid, 4'b0001 << i);
      check("rr_data", disp_data, 32'hB0 + i);
    end
    step(1'b0, '0, '0);
    check("empty_no_dispatch", disp_valid, 0);

    apply_reset();
    for (int i = 0; i < 6; i++) step(1'b1, 32'hC0 + i, '1);
    for (int i = 0; i < 7; i++) step(1'b0, '0, '1);
    check("raise_not_yet", voltage_level, 0);
    step(1'b0, '0, '1);
    check("raise_voltage", voltage_level, 1);
    check("raise_freq_lags", frequency_level, 0);
    for (int i = 0; i < 3; i++) step(1'b0, '0, '1);
    check("raise_freq_settle", frequency_level, 0);
    step(1'b0, '0, '1);
    check("raise_freq", frequency_level, 1);

    seen = 1'b0;
    n = 0;
    while (!seen && n < 60) begin
      step(1'b0, '0, '0);
      n++;
      seen = (frequency_level == 2'd0);
    end
    check("lower_freq_seen", seen, 1);
    check("lower_volt_lags", voltage_level, 1);
    for (int i = 0; i < 3; i++) step(1'b0, '0, '0);
    check("lower_volt_settle", voltage_level, 1);
    step(1'b0, '0, '0);
    check("lower_volt", voltage_level, 0);
    check("lower_occupancy", occupancy, 0);

    apply_reset();
    for (int i = 0; i < 6; i++) step(1'b1, 32'hD0 + i, '1);
    for (int i = 0; i < 9; i++) step(1'b0, '0, '1);
    check("raisef_voltage", voltage_level, 1);
    apply_reset();
    for (int i = 0; i < 6; i++) step(1'b1, 32'hE0 + i, '1);
    for (int i = 0; i < 8; i++) step(1'b0, '0, '1);
    check("post_reset_idle_raise", voltage_level, 1);

    apply_reset();
    for (int i = 0; i < 5; i++) step(1'b1, 32'hF0 + i, '1);
    for (int i = 0; i < 6; i++) step(1'b0, '0, '0);
`ifdef DISPATCH_STATS_EN
    check("stats_five", dispatch_count, 5);
`else
    check("stats_disabled", dispatch_count, 0);
`endif

    apply_reset();
    for (int p = 0; p < 12; p++) begin
      pv = $urandom_range(20, 100);
      pb = $urandom_range(0, 100);
      if (p == 6) apply_reset();
      for (int i = 0; i < 150; i++) begin
        for (int c = 0; c < N; c++) b[c] = ($urandom_range(0, 99) < pb);
        step($urandom_range(0, 99) < pv, $urandom, b);
      end
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/task_dispatch_scheduler.md
TASK_DISPATCH_SCHEDULER -- requirements
Module: task_dispatch_scheduler

Interface
REQ-001 Parameter NUM_CORES, default 4: number of worker cores (2..16).
REQ-002 Parameter DATA_W, default 32: task descriptor width.
REQ-003 Parameter DEPTH, default 8: task queue depth; power of two, at least 4.
REQ-004 Parameter HI_THRESH, default 6: queue occupancy at or above which load is high.
REQ-005 Parameter LO_THRESH, default 2: queue occupancy at or below which load is low; must be below HI_THRESH.
REQ-006 Parameter HOLD, default 8: consecutive high or low cycles needed before a DVFS step.
REQ-007 Parameter SETTLE, default 4: cycles between the voltage step and the frequency step.
REQ-008 clk  in  1  single clock; all state updates on the rising edge.
REQ-009 rst_n  in  1  asynchronous, active-low reset.
REQ-010 task_valid  in  1  upstream task offered.
REQ-011 task_data  in  DATA_W  task descriptor.
REQ-012 task_ready  out  1  queue can accept a task; high when occupancy is below DEPTH.
REQ-013 core_busy  in  NUM_CORES  per-core busy flags.
REQ-014 disp_valid  out  NUM_CORES  one-hot or zero dispatch strobe, one cycle wide.
REQ-015 disp_data  out  DATA_W  descriptor accompanying disp_valid.
REQ-016 occupancy  out  clog2(DEPTH)+1  current queue count.
REQ-017 voltage_level  out  2  DVFS voltage level, 0 to 3.
REQ-018 frequency_level  out  2  DVFS frequency level, 0 to 3.
REQ-019 dispatch_count  out  16  dispatched-task statistic (see Configuration).

Function
REQ-020 A task SHALL enqueue on every cycle where task_valid and task_ready are both high.
REQ-021 The queue SHALL be FIFO; pointers wrap modulo DEPTH.
REQ-022 A core is eligible when its busy flag is low and it was not strobed in the previous cycle.
REQ-023 The queue is non-empty, there is at least one eligible core, and disp_valid is registered with one-cycle latency from the cycle the condition is met.
REQ-024 Core selection SHALL be round-robin: first eligible core searching upward, with wrap, from the last granted index plus one (start at core 0 after reset).
REQ-025 Simultaneous enqueue and dispatch SHALL leave occupancy unchanged; an enqueue into an empty queue may not dispatch in the same cycle.
REQ-026 Full queue: task_ready low and offered tasks are not accepted. Empty queue: disp_valid is zero.
REQ-027 DVFS FSM states are IDLE, RAISE_F, and LOWER_V. A high counter increments while occupancy is at or above HI_THRESH and clears otherwise; the low counter behaves the same for occupancy at or below LO_THRESH.
REQ-028 In IDLE, when the high counter reaches HOLD and voltage_level is below 3: voltage_level increments, the FSM goes to RAISE_F, and both counters clear.
REQ-029 RAISE_F lasts SETTLE cycles, then frequency_level increments and the FSM returns to IDLE.
REQ-030 In IDLE, when the low counter reaches HOLD and frequency_level is above 0: frequency_level decrements first, the FSM goes to LOWER_V, and after SETTLE cycles voltage_level decrements.
REQ-031 The counters SHALL hold at zero outside IDLE, so the frequency level never exceeds the voltage level.
REQ-032 Level 3 SHALL saturate on raise requests and level 0 SHALL saturate on lower requests, with no FSM state change.

Reset
REQ-033 Asserting rst_n low SHALL immediately clear queue pointers and contents validity, occupancy, disp_valid, disp_data, the round-robin pointer, both counters, dispatch_count, and both DVFS levels, and SHALL return the FSM to IDLE.
REQ-034 Reset asserted during RAISE_F or LOWER_V SHALL abandon the transition, leaving both levels at 0.
REQ-035 task_ready SHALL be high from the first edge after reset release.

Configuration
REQ-036 With DISPATCH_STATS_EN defined, dispatch_count SHALL increment per dispatch and saturate at 16'hFFFF.
REQ-037 Without DISPATCH_STATS_EN, dispatch_count SHALL be constant 0 and no counter logic is built.

Verification
REQ-038 Push 8 tasks with all cores busy: occupancy 8, task_ready 0, and a ninth task is not accepted.
REQ-039 Queue holds 4 tasks, all cores go idle: disp_valid sequence 0001, 0010, 0100, 1000, with disp_data in FIFO order.
REQ-040 Occupancy held at 6 for 8 cycles: voltage_level goes to 1, and frequency_level goes to 1 four cycles later.
REQ-041 From levels 1/1, occupancy held at 0 for 8 cycles: frequency_level goes to 0, and voltage_level goes to 0 four cycles later.
REQ-042 rst_n pulsed low in RAISE_F: levels 0, occupancy 0, and the FSM is in IDLE on release.
REQ-043 With DISPATCH_STATS_EN, after 5 dispatches dispatch_count reads 5; without it, dispatch_count reads 0.
